// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port among NP requesters,
// with per-port bounded locking and an in-order tag FIFO that routes read data back.
module sdram_port_arbiter #(
    parameter int NP       = 4,
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_DEPTH = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NP-1:0]    p_req,
    input  logic [NP-1:0]    p_write,
    input  logic [NP-1:0]    p_lock,
    input  logic [NP*AW-1:0] p_addr,
    input  logic [NP*DW-1:0] p_wdata,
    output logic [NP-1:0]    p_gnt,
    output logic [NP-1:0]    p_rvalid,
    output logic [DW-1:0]    p_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_write,
    output logic [AW-1:0]    m_addr,
    output logic [DW-1:0]    m_wdata,
    input  logic             m_rvalid,
    input  logic [DW-1:0]    m_rdata,
    output logic             err_orphan
);

    localparam int IDW = $clog2(NP);
    localparam int PW  = $clog2(RD_DEPTH);
    localparam int CW  = $clog2(RD_DEPTH + 1);
    localparam int LW  = $clog2(LOCK_MAX + 1);

    logic [IDW-1:0] last;
    logic           lock_valid;
    logic [IDW-1:0] lock_owner;
    logic [LW-1:0]  lock_cnt;

    logic [IDW-1:0] tag_mem [RD_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  tag_cnt;

    logic           out_free;
    logic           pop;
    logic           push;
    logic           rd_ok;
    logic [NP-1:0]  eligible;
    logic           lock_hold;
    logic           sel_valid;
    logic [IDW-1:0] sel_id;
    logic           grant;

    // Controller handshake: a command transfers on any cycle with m_valid && m_ready;
    // while m_valid && !m_ready the m_* outputs hold their value.
    assign out_free  = !m_valid || m_ready;
    assign pop       = m_rvalid && (tag_cnt != '0);
    // A pop in the same cycle frees a slot for the read being loaded.
    assign rd_ok     = (tag_cnt != CW'(RD_DEPTH)) || pop;
    assign eligible  = p_req & (p_write | {NP{rd_ok}});
    assign lock_hold = lock_valid && p_req[lock_owner] && (lock_cnt < LW'(LOCK_MAX));

    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_id    = '0;
        idx       = 0;
        if (lock_hold) begin
            // A held lock stalls everyone else even when the owner cannot issue.
            sel_valid = eligible[lock_owner];
            sel_id    = lock_owner;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                idx = (int'(last) + k) % NP;
                if (!sel_valid && eligible[idx]) begin
                    sel_valid = 1'b1;
                    sel_id    = IDW'(idx);
                end
            end
        end
    end

    assign grant = out_free && sel_valid;
    assign push  = grant && !p_write[sel_id];

    always_comb begin
        p_gnt = '0;
        if (grant && rst_n) begin
            p_gnt[sel_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            last       <= IDW'(NP - 1);
            lock_valid <= 1'b0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else begin
            if (out_free) begin
                m_valid <= grant;
                if (grant) begin
                    m_write <= p_write[sel_id];
                    m_addr  <= p_addr[sel_id*AW +: AW];
                    m_wdata <= p_wdata[sel_id*DW +: DW];
                end
            end
            if (grant) begin
                last <= sel_id;
                if (p_lock[sel_id]) begin
                    lock_valid <= 1'b1;
                    lock_owner <= sel_id;
                    lock_cnt   <= (lock_hold ? lock_cnt : LW'(0)) + LW'(1);
                end else begin
                    lock_valid <= 1'b0;
                    lock_cnt   <= '0;
                end
            end else if (lock_valid && !lock_hold) begin
                lock_valid <= 1'b0;
                lock_cnt   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_cnt    <= '0;
            p_rvalid   <= '0;
            p_rdata    <= '0;
            err_orphan <= 1'b0;
        end else begin
            p_rvalid <= '0;
            if (push) begin
                tag_mem[wr_ptr] <= sel_id;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr                    <= rd_ptr + PW'(1);
                p_rvalid[tag_mem[rd_ptr]] <= 1'b1;
                p_rdata                   <= m_rdata;
            end
            if (m_rvalid && (tag_cnt == '0)) begin
                err_orphan <= 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + CW'(1);
                2'b01:   tag_cnt <= tag_cnt - CW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: stimulus pushes expected grants, commands and
// read returns into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    p_req, p_write, p_lock;
  logic [NP*AW-1:0] p_addr;
  logic [NP*DW-1:0] p_wdata;
  logic [NP-1:0]    p_gnt, p_rvalid;
  logic [DW-1:0]    p_rdata;
  logic             m_valid, m_ready, m_write;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic             m_rvalid;
  logic [DW-1:0]    m_rdata;
  logic             err_orphan;

  logic [AW-1:0] addr_a [NP];
  logic [DW-1:0] wdata_a [NP];
  logic [NP-1:0] one_shot;
  logic [NP-1:0] seen_gnt = '0;

  logic [NP-1:0]       gnt_q [$];
  logic [AW+DW:0]      cmd_q [$];
  logic [NP+DW-1:0]    rd_q [$];

  int nvec = 0;
  int nfail = 0;

  sdram_port_arbiter #(.NP(NP), .AW(AW), .DW(DW), .RD_DEPTH(4), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_write(p_write), .p_lock(p_lock),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err_orphan(err_orphan)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      p_addr[i*AW +: AW]  = addr_a[i];
      p_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      seen_gnt = p_gnt;
      if (p_gnt != '0) begin
        nvec++;
        if (gnt_q.size() == 0) begin
          nfail++;
          $display("FAIL grant: got %b, required no grant", p_gnt);
        end else begin
          logic [NP-1:0] e;
          e = gnt_q.pop_front();
          if (e !== p_gnt) begin
            nfail++;
            $display("FAIL grant: got %b, required %b", p_gnt, e);
          end
        end
      end
      if (m_valid && m_ready) begin
        nvec++;
        if (cmd_q.size() == 0) begin
          nfail++;
          $display("FAIL cmd: got w=%b a=%h d=%h, required no command", m_write, m_addr, m_wdata);
        end else begin
          logic [AW+DW:0] c;
          c = cmd_q.pop_front();
          if (c !== {m_write, m_addr, m_wdata}) begin
            nfail++;
            $display("FAIL cmd: got w=%b a=%h d=%h, required w=%b a=%h d=%h",
                     m_write, m_addr, m_wdata, c[AW+DW], c[AW+DW-1:DW], c[DW-1:0]);
          end
        end
      end
      if (p_rvalid != '0) begin
        nvec++;
        if (rd_q.size() == 0) begin
          nfail++;
          $display("FAIL rdata: got rv=%b d=%h, required no read return", p_rvalid, p_rdata);
        end else begin
          logic [NP+DW-1:0] r;
          r = rd_q.pop_front();
          if (r !== {p_rvalid, p_rdata}) begin
            nfail++;
            $display("FAIL rdata: got rv=%b d=%h, required rv=%b d=%h",
                     p_rvalid, p_rdata, r[NP+DW-1:DW], r[DW-1:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic exp_grant(input int port, input bit with_cmd);
    logic [NP-1:0] g;
    g = '0;
    g[port] = 1'b1;
    gnt_q.push_back(g);
    if (with_cmd) cmd_q.push_back({p_write[port], addr_a[port], wdata_a[port]});
  endtask

  task automatic exp_read(input int port, input logic [DW-1:0] d);
    logic [NP-1:0] g;
    g = '0;
    g[port] = 1'b1;
    rd_q.push_back({g, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    p_req = p_req & ~(seen_gnt & one_shot);
  endtask

  task automatic check_drained(input string name);
    check({name, "_gnt_q"}, 32'(gnt_q.size()), 32'd0);
    check({name, "_cmd_q"}, 32'(cmd_q.size()), 32'd0);
    check({name, "_rd_q"}, 32'(rd_q.size()), 32'd0);
    gnt_q.delete();
    cmd_q.delete();
    rd_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    p_req = '0; p_write = '0; p_lock = '0; one_shot = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      addr_a[i]  = AW'(16'h0100 + i);
      wdata_a[i] = DW'(16'hA0A0 + i);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_fields", 32'({m_write, m_addr, m_wdata} != '0), 32'd0);
    check("rst_p_outs", 32'({p_gnt, p_rvalid, p_rdata}), 32'd0);
    check("rst_err", 32'(err_orphan), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: plain round robin over four writers
    m_ready = 1'b1;
    p_write = 4'b1111;
    p_req   = 4'b1111;
    exp_grant(0, 1); exp_grant(1, 1); exp_grant(2, 1); exp_grant(3, 1); exp_grant(0, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_m_valid", 32'(m_valid), 32'd1);
    end
    p_req = '0;
    repeat (2) step();
    check_drained("t1");

    // 2: two reads, data routed back in issue order
    one_shot = '1;
    p_write = '0;
    addr_a[2] = 16'h0040;
    addr_a[1] = 16'h0080;
    p_req = 4'b0110;
    exp_grant(1, 1); exp_grant(2, 1);
    repeat (3) step();
    m_rvalid = 1'b1; m_rdata = 16'hAAAA; exp_read(1, 16'hAAAA);
    step();
    m_rdata = 16'h5555; exp_read(2, 16'h5555);
    step();
    m_rvalid = 1'b0;
    repeat (2) step();
    check_drained("t2");

    // 3: port 0 locks for LOCK_MAX grants, then port 3, then port 0 again
    p_write = 4'b1111;
    p_lock  = 4'b0001;
    one_shot = 4'b1000;
    addr_a[0] = 16'h3000;
    addr_a[3] = 16'h3003;
    p_req = 4'b0001;
    exp_grant(0, 1);
    step();
    p_req = 4'b1001;
    for (int k = 0; k < 15; k++) exp_grant(0, 1);
    exp_grant(3, 1);
    exp_grant(0, 1);
    repeat (17) step();
    p_req = '0;
    p_lock = '0;
    repeat (2) step();
    check_drained("t3");

    // 4: tag FIFO full stalls the fifth read until a pop frees a slot
    one_shot = '0;
    p_write = '0;
    addr_a[1] = 16'h4000;
    p_req = 4'b0010;
    for (int k = 0; k < 4; k++) exp_grant(1, 1);
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_stall", 32'(p_gnt), 32'd0);
    end
    m_rvalid = 1'b1; m_rdata = 16'h1111;
    exp_grant(1, 1);
    exp_read(1, 16'h1111);
    #2;
    check("t4_pop_grant", 32'(p_gnt), 32'b0010);
    step();
    p_req = '0;
    for (int k = 0; k < 4; k++) begin
      m_rdata = DW'(16'h2000 + k);
      exp_read(1, DW'(16'h2000 + k));
      step();
    end
    m_rvalid = 1'b0;
    repeat (2) step();
    check_drained("t4");

    // 5: controller back-pressure holds the command and blocks grants
    one_shot = '1;
    p_write = 4'b1111;
    addr_a[2] = 16'h5002; wdata_a[2] = 16'h5A02;
    addr_a[3] = 16'h5003; wdata_a[3] = 16'h5A03;
    m_ready = 1'b0;
    p_req = 4'b0100;
    exp_grant(2, 1);
    step();
    p_req = p_req | 4'b1000;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5_hold_valid", 32'(m_valid), 32'd1);
      check("t5_hold_addr", 32'(m_addr), 32'h5002);
      check("t5_hold_wdata", 32'(m_wdata), 32'h5A02);
    end
    exp_grant(3, 1);
    m_ready = 1'b1;
    #2;
    check("t5_resume_grant", 32'(p_gnt), 32'b1000);
    repeat (3) step();
    check_drained("t5");

    // 6: orphan return, async reset, and tags discarded by reset
    m_rvalid = 1'b1; m_rdata = 16'hDEAD;
    step();
    m_rvalid = 1'b0;
    check("t6_orphan_err", 32'(err_orphan), 32'd1);
    check("t6_orphan_rvalid", 32'(p_rvalid), 32'd0);
    m_ready = 1'b0;
    p_write = '0;
    addr_a[0] = 16'h6000;
    p_req = 4'b0001;
    exp_grant(0, 0);
    repeat (2) step();
    check("t6_pending_valid", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_err", 32'(err_orphan), 32'd0);
    check("t6_async_valid", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    step();
    m_rvalid = 1'b1; m_rdata = 16'hBEEF;
    step();
    m_rvalid = 1'b0;
    check("t6_discard_err", 32'(err_orphan), 32'd1);
    check("t6_discard_rvalid", 32'(p_rvalid), 32'd0);
    check("t6_no_cmd", 32'(m_valid), 32'd0);
    step();
    check_drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
